// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator for the HDMI/TMDS output stage (pixel clock domain).
//   Free-running x/y counters drive the renderer request (x, y, active).
//   Stage-0 timing (de/hsync/vsync/frame/line strobes) and an 8-bar test
//   pattern are delayed by PIPE_LAT cycles so they line up with rgb_in coming
//   back from the renderer. Everything then passes through one output register.
//
// Ports
//   clk_pix      in   pixel clock (only clock)
//   rst          in   synchronous reset, active high
//   pattern_en   in   1 = send the colour-bar pattern, 0 = send rgb_in
//   x, y         out  current counters (renderer request), CW bits each
//   active       out  (x < H_ACTIVE) && (y < V_ACTIVE), combinational
//   rgb_in       in   {r,g,b} from the renderer, PIPE_LAT cycles after x/y
//   r, g, b      out  registered pixel data, forced to 0 outside de
//   de           out  registered data enable
//   hsync, vsync out  registered syncs, asserted level = H_POL / V_POL
//   frame_start  out  one-cycle pulse with output pixel (0,0)
//   line_start   out  one-cycle pulse with output pixel x=0 of each active line
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE_LAT = 2,
  parameter int CW       = 12
) (
  input  logic          clk_pix,
  input  logic          rst,
  input  logic          pattern_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  input  logic [23:0]   rgb_in,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BW      = H_ACTIVE / 8;

  localparam logic [CW-1:0] HA_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HSB_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSE_C = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] HTM_C = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VA_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VSB_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSE_C = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] VTM_C = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] BWM_C = CW'(BW - 1);

  // Bar index -> {R,G,B}, each component fully on or off.
  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = 24'hFFFFFF; // white
      3'd1:    bar_colour = 24'hFFFF00; // yellow
      3'd2:    bar_colour = 24'h00FFFF; // cyan
      3'd3:    bar_colour = 24'h00FF00; // green
      3'd4:    bar_colour = 24'hFF00FF; // magenta
      3'd5:    bar_colour = 24'hFF0000; // red
      3'd6:    bar_colour = 24'h0000FF; // blue
      default: bar_colour = 24'h000000; // black
    endcase
  endfunction

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [CW-1:0] r_bw_cnt;
  logic [2:0]    r_bar;
  logic          w_x_wrap;
  logic          w_y_wrap;

  assign w_x_wrap = (r_x == HTM_C);
  assign w_y_wrap = (r_y == VTM_C);

  // Counters. The bar counter tracks x so the pattern is ready at stage 0;
  // it restarts with x and may wrap freely during blanking (de masks it).
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_bw_cnt <= '0;
      r_bar    <= '0;
    end else if (w_x_wrap) begin
      r_x      <= '0;
      r_y      <= w_y_wrap ? '0 : r_y + 1'b1;
      r_bw_cnt <= '0;
      r_bar    <= '0;
    end else begin
      r_x <= r_x + 1'b1;
      if (r_bw_cnt == BWM_C) begin
        r_bw_cnt <= '0;
        r_bar    <= r_bar + 1'b1;
      end else begin
        r_bw_cnt <= r_bw_cnt + 1'b1;
      end
    end
  end

  // ---- stage 0: timing decoded combinationally from the counters ----
  logic        w_de0;
  logic        w_hs0;
  logic        w_vs0;
  logic        w_ls0;
  logic        w_fs0;
  logic [4:0]  w_ctl0;
  logic [23:0] w_pat0;

  assign w_de0  = (r_x < HA_C) && (r_y < VA_C);
  assign w_hs0  = (r_x >= HSB_C) && (r_x < HSE_C);
  assign w_vs0  = (r_y >= VSB_C) && (r_y < VSE_C);
  assign w_ls0  = w_de0 && (r_x == '0);
  assign w_fs0  = w_ls0 && (r_y == '0);
  assign w_ctl0 = {w_fs0, w_ls0, w_vs0, w_hs0, w_de0};
  assign w_pat0 = bar_colour(r_bar);

  assign x      = r_x;
  assign y      = r_y;
  assign active = w_de0;

  // ---- stages 1..PIPE_LAT: match the renderer latency ----
  logic [4:0]  w_ctl_d;
  logic [23:0] w_pat_d;

  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign w_ctl_d = w_ctl0;
      assign w_pat_d = w_pat0;
    end else begin : g_dly
      logic [4:0]  r_ctl_p [PIPE_LAT];
      logic [23:0] r_pat_p [PIPE_LAT];

      // Clearing the control stages on reset is what prevents a stale or
      // truncated sync pulse from leaking out after reset.
      always_ff @(posedge clk_pix) begin
        if (rst) begin
          for (int i = 0; i < PIPE_LAT; i++) r_ctl_p[i] <= '0;
        end else begin
          r_ctl_p[0] <= w_ctl0;
          for (int i = 1; i < PIPE_LAT; i++) r_ctl_p[i] <= r_ctl_p[i-1];
        end
      end

      always_ff @(posedge clk_pix) begin
        r_pat_p[0] <= w_pat0;
        for (int i = 1; i < PIPE_LAT; i++) r_pat_p[i] <= r_pat_p[i-1];
      end

      assign w_ctl_d = r_ctl_p[PIPE_LAT-1];
      assign w_pat_d = r_pat_p[PIPE_LAT-1];
    end
  endgenerate

  // ---- output register ----
  logic [23:0] r_rgb;
  logic        r_de;
  logic        r_hs;
  logic        r_vs;
  logic        r_fs;
  logic        r_ls;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_rgb <= '0;
      r_de  <= 1'b0;
      r_hs  <= ~H_POL;
      r_vs  <= ~V_POL;
      r_fs  <= 1'b0;
      r_ls  <= 1'b0;
    end else begin
      r_rgb <= w_ctl_d[0] ? (pattern_en ? w_pat_d : rgb_in) : 24'h000000;
      r_de  <= w_ctl_d[0];
      r_hs  <= w_ctl_d[1] ~^ H_POL;
      r_vs  <= w_ctl_d[2] ~^ V_POL;
      r_ls  <= w_ctl_d[3];
      r_fs  <= w_ctl_d[4];
    end
  end

  assign r           = r_rgb[23:16];
  assign g           = r_rgb[15:8];
  assign b           = r_rgb[7:0];
  assign de          = r_de;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign frame_start = r_fs;
  assign line_start  = r_ls;

endmodule
